dcj11_mem_bridge: RTL
=====================

DCJ11_MEM_BRIDGE -- requirements
Module: dcj11_mem_bridge

Interface
REQ-001 SHALL have parameter WPOST_DEPTH, default 2, posted-write buffer depth in entries (power of two, 2..8).
REQ-002 SHALL have port clk_x3  in  1  54 MHz system clock; all logic on its rising edge.
REQ-003 SHALL have port rstb  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port init  in  1  PSRAM controller calibrated and ready.
REQ-005 SHALL have ports ram_addr in 22 (byte address), ram_read in 1 (level), ram_write in 1 (level), ram_byte in 1, ram_wdata in 16: CPU-side request, synchronous to clk_x3.
REQ-006 SHALL have ports ram_rdata out 16 (read data), rd_valid out 1 (ram_rdata valid), busy out 1, wr_ovf out 1 (sticky overflow).
REQ-007 SHALL have ports cmd_valid out 1, cmd_ready in 1, cmd_write out 1, cmd_addr out 21 (word address), cmd_wdata out 16, cmd_mask out 2 (byte enables, active high): controller command channel.
REQ-008 SHALL have ports rsp_valid in 1, rsp_data in 16: read response, one-cycle pulse; writes return no response.

Function
REQ-009 SHALL detect requests on rising edges of ram_read and ram_write only; a held level is not a new request.
REQ-010 SHALL set cmd_addr to ram_addr[21:1].
REQ-011 SHALL set cmd_mask: word write 2'b11; byte write, addr[0]=0, 2'b01; addr[0]=1, 2'b10; reads 2'b11.
REQ-012 SHALL pass ram_wdata unchanged to cmd_wdata; lane placement is the CPU's.
REQ-013 SHALL implement FSM IDLE, RD_REQ, RD_WAIT, WR_REQ.
REQ-014 IDLE: posted write pending and init=1 -> WR_REQ; else read pending and init=1 -> RD_REQ.
REQ-015 RD_REQ: cmd_valid=1, cmd_write=0; cmd_ready=1 -> RD_WAIT.
REQ-016 RD_WAIT: cmd_valid=0; rsp_valid=1 -> latch rsp_data into ram_rdata, rd_valid=1 next cycle, -> IDLE.
REQ-017 WR_REQ: cmd_valid=1, cmd_write=1, head entry presented; cmd_ready=1 -> pop entry, -> IDLE.
REQ-018 cmd_* SHALL stay stable while cmd_valid=1 and cmd_ready=0.
REQ-019 Read edge in cycle N with IDLE, empty buffer, init=1 SHALL give cmd_valid=1 in cycle N+1.
REQ-020 rd_valid SHALL clear on ram_read falling edge or a new read edge; ram_rdata holds its last value.
REQ-021 Reads SHALL be ordered after every write already posted; no forwarding.
REQ-022 Only one read SHALL be pending; a read edge while a read is pending or in flight is ignored.
REQ-023 Same-cycle read and write edges: write captured first, read serviced after it.
REQ-024 Write edge with buffer full SHALL drop the write and set wr_ovf until reset.
REQ-025 init=0: cmd_valid SHALL be 0; requests are still captured, drained once init=1.
REQ-026 busy SHALL be 1 when state != IDLE, buffer non-empty or read pending.

Reset
REQ-027 rstb=1 SHALL force IDLE, empty buffer, no pending read, cmd_valid=0, cmd_write=0, cmd_addr=0, cmd_wdata=0, cmd_mask=0, ram_rdata=0, rd_valid=0, wr_ovf=0, busy=0.
REQ-028 Reset mid-transaction SHALL abandon it; a later rsp_valid in IDLE is ignored.

Configuration
REQ-029 Macro DCJ11_WPOST_EN: defined -> writes enter the WPOST_DEPTH buffer, CPU never stalls on writes.
REQ-030 Without DCJ11_WPOST_EN -> single-entry holding register; wr_ovf is 1 if a write edge arrives while it is occupied, that write dropped; the rest unchanged.

Structure
REQ-031 Package dcj11_mem_pkg SHALL hold the FSM state enum, address/data width constants and cmd_mask constants.
REQ-032 Posted-write buffer SHALL be sub-module wpost_fifo (synchronous FIFO: push, pop, full, empty, 40-bit entry {addr21, data16, mask2, spare1}).

Verification
REQ-033 init=1, read edge addr 22'o001000, cmd_ready=1, rsp_data=16'o123456 after 4 cycles -> cmd_addr 21'o000400, ram_rdata=16'o123456, rd_valid=1.
REQ-034 Byte write addr 22'o001001, data 16'hAB00 -> cmd_write=1, cmd_mask=2'b10, cmd_wdata=16'hAB00.
REQ-035 Two writes, then read edge, cmd_ready=0 for 10 cycles -> both writes issued in order before the read; busy=1 throughout.
REQ-036 DCJ11_WPOST_EN, WPOST_DEPTH=2, cmd_ready=0, three write edges -> third dropped, wr_ovf=1, first two drain later.
REQ-037 init=0, read edge, init=1 after 20 cycles -> cmd_valid stays 0 until init=1, then read issued.
REQ-038 rstb=1 during RD_WAIT, rsp_valid next cycle -> rd_valid stays 0, all outputs at reset values.

Source files
------------

// File: rtl/dcj11_mem_pkg.sv
// Shared types and constants for the DCJ11 CPU to PSRAM controller bridge.
package dcj11_mem_pkg;

  localparam int unsigned ADDR_W  = 22;
  localparam int unsigned WADDR_W = 21;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ENTRY_W = 40;

  localparam logic [1:0] MASK_WORD = 2'b11;
  localparam logic [1:0] MASK_LO   = 2'b01;
  localparam logic [1:0] MASK_HI   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ
  } state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [DATA_W-1:0]  data;
    logic [1:0]         mask;
    logic               spare;
  } wpost_entry_t;

  function automatic logic [1:0] wr_mask(input logic is_byte, input logic a0);
    if (!is_byte) return MASK_WORD;
    return a0 ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/dcj11_mem_bridge_wpost_fifo.sv
// wpost_fifo: synchronous FIFO holding posted CPU writes until the controller takes them.
module wpost_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk_x3,
  input  logic             rstb,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [1 << PW];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk_x3) begin
    if (rstb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_x3) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/dcj11_mem_bridge.sv
// DCJ11 CPU request to PSRAM controller command bridge with write posting.
// DCJ11_WPOST_EN: defined -> WPOST_DEPTH-entry posted-write buffer; undefined -> one-entry holding register.
module dcj11_mem_bridge
  import dcj11_mem_pkg::*;
#(
  parameter int unsigned WPOST_DEPTH = 2
) (
  input  logic               clk_x3,
  input  logic               rstb,
  input  logic               init,
  input  logic [ADDR_W-1:0]  ram_addr,
  input  logic               ram_read,
  input  logic               ram_write,
  input  logic               ram_byte,
  input  logic [DATA_W-1:0]  ram_wdata,
  output logic [DATA_W-1:0]  ram_rdata,
  output logic               rd_valid,
  output logic               busy,
  output logic               wr_ovf,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               cmd_write,
  output logic [WADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0]  cmd_wdata,
  output logic [1:0]         cmd_mask,
  input  logic               rsp_valid,
  input  logic [DATA_W-1:0]  rsp_data
);
`ifdef DCJ11_WPOST_EN
  localparam int unsigned BUF_DEPTH = WPOST_DEPTH;
`else
  localparam int unsigned BUF_DEPTH = (WPOST_DEPTH < 1) ? WPOST_DEPTH : 1;
`endif

  state_t             r_state, w_state_nxt;
  logic               r_read_d, r_write_d;
  logic               r_rd_pend;
  logic [WADDR_W-1:0] r_rd_addr;
  logic               r_cmd_valid, r_cmd_write;
  logic [WADDR_W-1:0] r_cmd_addr;
  logic [DATA_W-1:0]  r_cmd_wdata, r_rdata;
  logic [1:0]         r_cmd_mask;
  logic               r_rd_valid, r_wr_ovf;
  logic               w_rd_edge, w_wr_edge, w_rd_fall, w_rd_accept;
  logic               w_push, w_pop, w_full, w_empty;
  logic               w_unused_spare;
  wpost_entry_t       w_entry, w_head;

  assign w_rd_edge = ram_read & ~r_read_d;
  assign w_wr_edge = ram_write & ~r_write_d;
  assign w_rd_fall = ~ram_read & r_read_d;
  assign w_push    = w_wr_edge & ~w_full;
  assign w_pop     = (r_state == ST_WR_REQ) & cmd_ready;
  // Only one read outstanding: edges during RD_REQ/RD_WAIT or with a read pending are ignored.
  assign w_rd_accept = w_rd_edge & ~r_rd_pend &
                       ((r_state == ST_IDLE) | (r_state == ST_WR_REQ));

  assign w_entry = '{addr: ram_addr[ADDR_W-1:1], data: ram_wdata,
                     mask: wr_mask(ram_byte, ram_addr[0]), spare: 1'b0};
  assign w_unused_spare = w_head.spare;

  wpost_fifo #(
    .DEPTH (BUF_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_wpost (
    .clk_x3  (clk_x3),
    .rstb    (rstb),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_entry),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Same-cycle edges are looked at directly so a fresh request issues the next cycle;
  // a write being pushed this cycle still wins over any read.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (init && (!w_empty || w_push))
          w_state_nxt = ST_WR_REQ;
        else if (init && (r_rd_pend || w_rd_accept))
          w_state_nxt = ST_RD_REQ;
      end
      ST_RD_REQ:  if (cmd_ready) w_state_nxt = ST_RD_WAIT;
      ST_RD_WAIT: if (rsp_valid) w_state_nxt = ST_IDLE;
      ST_WR_REQ:  if (cmd_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_x3) begin
    r_read_d  <= ram_read;
    r_write_d <= ram_write;
    if (rstb) begin
      r_state     <= ST_IDLE;
      r_rd_pend   <= 1'b0;
      r_rd_addr   <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
      r_cmd_mask  <= '0;
      r_rdata     <= '0;
      r_rd_valid  <= 1'b0;
      r_wr_ovf    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_valid <= (w_state_nxt == ST_RD_REQ) || (w_state_nxt == ST_WR_REQ);
      r_cmd_write <= (w_state_nxt == ST_WR_REQ);
      if (w_wr_edge && w_full) r_wr_ovf <= 1'b1;
      if (w_rd_accept) r_rd_addr <= ram_addr[ADDR_W-1:1];

      if (r_state == ST_IDLE && w_state_nxt == ST_RD_REQ)
        r_rd_pend <= 1'b0;
      else if (w_rd_accept)
        r_rd_pend <= 1'b1;

      if (r_state == ST_IDLE && w_state_nxt == ST_WR_REQ) begin
        r_cmd_addr  <= w_empty ? w_entry.addr : w_head.addr;
        r_cmd_wdata <= w_empty ? w_entry.data : w_head.data;
        r_cmd_mask  <= w_empty ? w_entry.mask : w_head.mask;
      end else if (r_state == ST_IDLE && w_state_nxt == ST_RD_REQ) begin
        r_cmd_addr  <= r_rd_pend ? r_rd_addr : ram_addr[ADDR_W-1:1];
        r_cmd_wdata <= '0;
        r_cmd_mask  <= MASK_WORD;
      end

      if (r_state == ST_RD_WAIT && rsp_valid) begin
        r_rdata    <= rsp_data;
        r_rd_valid <= 1'b1;
      end else if (w_rd_fall || w_rd_edge) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_write = r_cmd_write;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_wdata = r_cmd_wdata;
  assign cmd_mask  = r_cmd_mask;
  assign ram_rdata = r_rdata;
  assign rd_valid  = r_rd_valid;
  assign wr_ovf    = r_wr_ovf;
  assign busy      = (r_state != ST_IDLE) | ~w_empty | r_rd_pend;

endmodule
